// File: rtl/lim_counter_chain.sv
// Cascaded 0..LIM digit counter with single-cycle carry/borrow ripple,
// run/hold control, parallel load, terminal-count pulse and sticky overflow.
module lim_counter_chain #(
  parameter  int DIGITS   = 4,
  parameter  int LIM      = 9,
  parameter  int AUTOSTOP = 0,
  localparam int N        = $clog2(LIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DIGITS*N-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic                  tick,
  output logic [DIGITS*N-1:0]   count,
  output logic                  running,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [N-1:0] LIM_D = N'(LIM);
  localparam logic [N:0]   LIM_E = (N+1)'(LIM);

  logic [DIGITS*N-1:0] r_count;
  logic [1:0]          r_state;
  logic                r_tc;
  logic                r_ovf;

  logic [DIGITS*N-1:0] w_next;
  logic [DIGITS:0]     w_chain;
  logic [1:0]          w_state_nxt;
  logic                w_step;
  logic                w_tc_hit;

  // w_chain[i] is the carry (up) or borrow (down) into digit i; digit 0 always steps.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_chain    = '0;
    w_chain[0] = 1'b1;
    w_next     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dir) begin
        if (({1'b0, r_count[i*N +: N]} + (N+1)'(w_chain[i])) > LIM_E) begin
          w_next[i*N +: N] = '0;
          w_chain[i+1]     = 1'b1;
        end else begin
          w_next[i*N +: N] = r_count[i*N +: N] + N'(w_chain[i]);
        end
      end else begin
        // Out-of-range digits clamp to LIM without borrowing onward.
        if (r_count[i*N +: N] > LIM_D) begin
          w_next[i*N +: N] = LIM_D;
        end else if (w_chain[i] && (r_count[i*N +: N] == '0)) begin
          w_next[i*N +: N] = LIM_D;
          w_chain[i+1]     = 1'b1;
        end else begin
          w_next[i*N +: N] = r_count[i*N +: N] - N'(w_chain[i]);
        end
      end
    end
  end

  assign w_step   = (r_state == ST_RUN) && tick && !clr && !load;
  assign w_tc_hit = w_step && w_chain[DIGITS];

  // stop beats start; with AUTOSTOP a terminal count forces HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop)                                w_state_nxt = ST_HOLD;
        else if ((AUTOSTOP != 0) && w_tc_hit)    w_state_nxt = ST_HOLD;
      end
      ST_HOLD: if (start && !stop) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_tc    <= 1'b0;
    end else begin
      r_tc    <= w_tc_hit;
      r_state <= w_state_nxt;
      if (w_tc_hit) r_ovf <= 1'b1;
      if (w_step && !((AUTOSTOP != 0) && w_tc_hit)) r_count <= w_next;
    end
  end

  assign count   = r_count;
  assign running = (r_state == ST_RUN);
  assign tc      = r_tc;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_lim_counter_chain.sv
// Directed bench for lim_counter_chain: a wrapping instance (u0) and an
// AUTOSTOP instance (u1), digits packed N=5 bits each for LIM=9.
module tb_lim_counter_chain;

  localparam int DIGITS = 4;
  localparam int LIM    = 9;
  localparam int N      = $clog2(LIM) + 1;
  localparam int W      = DIGITS * N;

  logic clk = 1'b0;
  logic rst_n;

  logic         clr, load, start, stop, dir, tick;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         running, tc, ovf;

  logic         a_clr, a_load, a_start, a_stop, a_dir, a_tick;
  logic [W-1:0] a_load_val;
  logic [W-1:0] a_count;
  logic         a_running, a_tc, a_ovf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lim_counter_chain #(.DIGITS(DIGITS), .LIM(LIM), .AUTOSTOP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .dir(dir), .tick(tick),
    .count(count), .running(running), .tc(tc), .ovf(ovf)
  );

  lim_counter_chain #(.DIGITS(DIGITS), .LIM(LIM), .AUTOSTOP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .start(a_start), .stop(a_stop), .dir(a_dir), .tick(a_tick),
    .count(a_count), .running(a_running), .tc(a_tc), .ovf(a_ovf)
  );

  function automatic logic [W-1:0] pk(input int d3, input int d2, input int d1, input int d0);
    logic [W-1:0] v;
    v = '0;
    v[0*N +: N] = N'(d0);
    v[1*N +: N] = N'(d1);
    v[2*N +: N] = N'(d2);
    v[3*N +: N] = N'(d3);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {clr, load, start, stop, dir, tick} = '0;
    load_val = '0;
    {a_clr, a_load, a_start, a_stop, a_dir, a_tick} = '0;
    a_load_val = '0;
    #12;
    check("rst_count",   32'(count), 32'(0));
    check("rst_running", 32'(running), 32'(0));
    check("rst_tc",      32'(tc), 32'(0));
    check("rst_ovf",     32'(ovf), 32'(0));
    cyc();
    rst_n = 1'b1;

    // Ticks in IDLE are ignored.
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    check("idle_tick_count", 32'(count), 32'(0));

    load = 1'b1; load_val = pk(0, 9, 9, 9); cyc(); load = 1'b0;
    check("load_0999", 32'(count), 32'(pk(0, 9, 9, 9)));
    start = 1'b1; cyc(); start = 1'b0;
    check("start_running", 32'(running), 32'(1));

    tick = 1'b1; cyc(); tick = 1'b0;
    check("ripple_up_1000", 32'(count), 32'(pk(1, 0, 0, 0)));
    check("ripple_up_tc0",  32'(tc), 32'(0));

    load = 1'b1; load_val = pk(9, 9, 9, 9); cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("wrap_up_count", 32'(count), 32'(0));
    check("wrap_up_tc",    32'(tc), 32'(1));
    check("wrap_up_ovf",   32'(ovf), 32'(1));
    cyc();
    check("tc_one_cycle",  32'(tc), 32'(0));
    check("ovf_sticky",    32'(ovf), 32'(1));

    // Down with borrow ripple, then wrap to all-LIM.
    dir = 1'b1;
    load = 1'b1; load_val = pk(1, 0, 0, 0); cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("borrow_0999",  32'(count), 32'(pk(0, 9, 9, 9)));
    check("borrow_tc0",   32'(tc), 32'(0));
    load = 1'b1; load_val = pk(0, 0, 0, 0); cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("wrap_dn_count", 32'(count), 32'(pk(9, 9, 9, 9)));
    check("wrap_dn_tc",    32'(tc), 32'(1));

    // Illegal digit values normalise.
    dir = 1'b0;
    load = 1'b1; load_val = pk(0, 0, 3, 12); cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("illegal_up", 32'(count), 32'(pk(0, 0, 4, 0)));
    dir = 1'b1;
    load = 1'b1; load_val = pk(0, 0, 3, 13); cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("illegal_dn", 32'(count), 32'(pk(0, 0, 3, 9)));
    check("illegal_dn_tc0", 32'(tc), 32'(0));

    // start+stop together in RUN -> HOLD; ticks in HOLD ignored.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("startstop_hold", 32'(running), 32'(0));
    tick = 1'b1; cyc(); tick = 1'b0;
    check("hold_tick_count", 32'(count), 32'(pk(0, 0, 3, 9)));
    start = 1'b1; cyc(); start = 1'b0;
    check("hold_to_run", 32'(running), 32'(1));

    // load beats tick in the same cycle.
    load = 1'b1; tick = 1'b1; load_val = pk(0, 1, 2, 3); cyc(); load = 1'b0; tick = 1'b0;
    check("load_over_tick", 32'(count), 32'(pk(0, 1, 2, 3)));
    check("load_over_tick_run", 32'(running), 32'(1));

    // clr beats load.
    clr = 1'b1; load = 1'b1; load_val = pk(5, 5, 5, 5); cyc(); clr = 1'b0; load = 1'b0;
    check("clr_count",   32'(count), 32'(0));
    check("clr_running", 32'(running), 32'(0));
    check("clr_ovf",     32'(ovf), 32'(0));
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("idle_startstop", 32'(running), 32'(0));
    start = 1'b1; cyc(); start = 1'b0;

    // Direction changes between ticks.
    dir = 1'b0; tick = 1'b1; cyc();
    dir = 1'b1; cyc();
    dir = 1'b0; cyc(); tick = 1'b0;
    check("dir_change", 32'(count), 32'(pk(0, 0, 0, 1)));
    check("dir_change_ovf", 32'(ovf), 32'(0));

    // Set ovf, then load 0375 and reset asynchronously mid-run.
    dir = 1'b1; load = 1'b1; load_val = '0; cyc(); load = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    dir = 1'b0; load = 1'b1; load_val = pk(0, 3, 7, 5); cyc(); load = 1'b0;
    tick = 1'b1; cyc();
    check("pre_rst_count", 32'(count), 32'(pk(0, 3, 7, 6)));
    check("pre_rst_ovf",   32'(ovf), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count",   32'(count), 32'(0));
    check("async_rst_running", 32'(running), 32'(0));
    check("async_rst_tc",      32'(tc), 32'(0));
    check("async_rst_ovf",     32'(ovf), 32'(0));
    cyc();
    rst_n = 1'b1;
    cyc(); cyc(); tick = 1'b0;
    check("post_rst_idle", 32'(count), 32'(0));

    // AUTOSTOP instance: saturate at terminal count and drop to HOLD.
    a_load = 1'b1; a_load_val = pk(9, 9, 9, 8); cyc(); a_load = 1'b0;
    a_start = 1'b1; cyc(); a_start = 1'b0;
    a_tick = 1'b1; cyc();
    check("as_9999",     32'(a_count), 32'(pk(9, 9, 9, 9)));
    check("as_tc0",      32'(a_tc), 32'(0));
    cyc(); a_tick = 1'b0;
    check("as_hold_cnt", 32'(a_count), 32'(pk(9, 9, 9, 9)));
    check("as_tc1",      32'(a_tc), 32'(1));
    check("as_stopped",  32'(a_running), 32'(0));
    check("as_ovf",      32'(a_ovf), 32'(1));
    cyc();
    check("as_tc_drop",  32'(a_tc), 32'(0));
    a_start = 1'b1; cyc(); a_start = 1'b0;
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    check("as_again_tc",  32'(a_tc), 32'(1));
    check("as_again_cnt", 32'(a_count), 32'(pk(9, 9, 9, 9)));
    check("as_again_run", 32'(a_running), 32'(0));

    // AUTOSTOP downwards holds at all-zero.
    a_dir = 1'b1; a_load = 1'b1; a_load_val = '0; cyc(); a_load = 1'b0;
    a_start = 1'b1; cyc(); a_start = 1'b0;
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    check("as_dn_cnt", 32'(a_count), 32'(0));
    check("as_dn_tc",  32'(a_tc), 32'(1));
    check("as_dn_run", 32'(a_running), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
